// File: rtl/pkt_rr_allocator.sv
// pkt_rr_allocator: wormhole output allocator with round-robin head arbitration and a lock watchdog
module pkt_rr_allocator #(
    parameter int CNT_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       req,
    input  logic [14:0]      flit_id,
    input  logic             out_ready,
    input  logic [CNT_W-1:0] timeout_max,
    output logic [4:0]       grant,
    output logic [2:0]       sel,
    output logic             out_valid,
    output logic             timeout_err
);
    typedef enum logic {IDLE, LOCKED} state_t;
    state_t state, state_n;
    logic [4:0] grant_n, heads, tails, elig, cand;
    logic [2:0] sel_n, ptr, ptr_n, win;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic locked, xfer, tail_xfer, abort, expire, release_now, found, timeout_err_n;

    function automatic logic [3:0] rr_pick(input logic [4:0] el, input logic [2:0] p);
        logic [2:0] i;
        rr_pick = 4'd0;
        // scan backwards so the port closest to p is written last and wins
        for (int k = 4; k >= 0; k--) begin
            i = 3'((int'(p) + k) % 5);
            if (el[i]) rr_pick = {1'b1, i};
        end
    endfunction

    for (genvar g = 0; g < 5; g++) begin : g_flit
        assign heads[g] = flit_id[3*g];
        assign tails[g] = flit_id[3*g+2];
    end

    assign out_valid = |(req & grant);

    always_comb begin
        locked        = state == LOCKED;
        xfer          = out_valid & out_ready;
        tail_xfer     = xfer & |(grant & tails);
        abort         = locked & ~out_valid;
        expire        = locked & ~xfer & (timeout_max != '0) & (cnt == timeout_max);
        release_now   = locked & (tail_xfer | abort | expire);
        elig          = req & heads;
        // the releasing owner sits out this arbitration round
        cand          = locked ? (release_now ? (elig & ~grant) : 5'd0) : elig;
        {found, win}  = rr_pick(cand, ptr);
        state_n       = (found | (locked & ~release_now)) ? LOCKED : IDLE;
        grant_n       = found ? (5'd1 << win) : (release_now ? 5'd0 : grant);
        sel_n         = found ? win : (release_now ? 3'd7 : sel);
        ptr_n         = found ? ((win == 3'd4) ? 3'd0 : win + 3'd1) : ptr;
        cnt_n         = (found | xfer) ? '0 : ((locked & ~&cnt) ? cnt + CNT_W'(1) : cnt);
        timeout_err_n = expire;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            grant       <= 5'd0;
            sel         <= 3'd7;
            ptr         <= 3'd0;
            cnt         <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_n;
            grant       <= grant_n;
            sel         <= sel_n;
            ptr         <= ptr_n;
            cnt         <= cnt_n;
            timeout_err <= timeout_err_n;
        end
    end
endmodule

// File: tb/tb_pkt_rr_allocator.sv
// tb_pkt_rr_allocator: directed and random stimulus scored against a packet-level reference model
module tb_pkt_rr_allocator;
    localparam int CW = 12;
    localparam int CMAX = (1 << CW) - 1;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [4:0] req = '0;
    logic [14:0] flit_id = '0;
    logic out_ready = 1'b0;
    logic [CW-1:0] timeout_max = '0;
    logic [4:0] grant;
    logic [2:0] sel;
    logic out_valid, timeout_err;

    typedef struct {int owner; bit terr;} exp_t;
    exp_t q[$];
    int checks = 0, errors = 0;
    int m_owner = -1, m_ptr = 0, m_cnt = 0;

    pkt_rr_allocator #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .req(req), .flit_id(flit_id), .out_ready(out_ready),
        .timeout_max(timeout_max), .grant(grant), .sel(sel), .out_valid(out_valid),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    function automatic logic [14:0] fl(input logic [2:0] l, n, e, w, s);
        return {s, w, e, n, l};
    endfunction

    function automatic int pick(input logic [4:0] rq, input logic [14:0] f, input int excl);
        int i;
        for (int k = 0; k < 5; k++) begin
            i = (m_ptr + k) % 5;
            if (i != excl && rq[i] && f[3*i]) return i;
        end
        return -1;
    endfunction

    task automatic chk(input string n, input logic [7:0] a, input logic [7:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    // apply one cycle of inputs and record what the allocator must show after the next edge
    task automatic step(input bit r, input logic [4:0] rq, input logic [14:0] f, input bit rdy, input int tm);
        bit terr, xfer, done, to;
        int w;
        @(negedge clk);
        rst = r; req = rq; flit_id = f; out_ready = rdy; timeout_max = tm[CW-1:0];
        terr = 0;
        if (r) begin
            m_owner = -1; m_ptr = 0; m_cnt = 0;
        end else if (m_owner < 0) begin
            w = pick(rq, f, -1);
            if (w >= 0) begin m_owner = w; m_ptr = (w + 1) % 5; m_cnt = 0; end
        end else begin
            xfer = rq[m_owner] && rdy;
            done = xfer && f[3*m_owner+2];
            to = tm != 0 && m_cnt == tm && !xfer;
            m_cnt = xfer ? 0 : (m_cnt < CMAX ? m_cnt + 1 : CMAX);
            if (done || !rq[m_owner] || to) begin
                terr = to;
                w = pick(rq, f, m_owner);
                m_owner = w;
                if (w >= 0) begin m_ptr = (w + 1) % 5; m_cnt = 0; end
            end
        end
        q.push_back('{m_owner, terr});
    endtask

    initial begin : monitor
        exp_t e;
        logic [4:0] eg;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                eg = (e.owner < 0) ? 5'd0 : 5'(1 << e.owner);
                chk("grant", 8'(grant), 8'(eg));
                chk("sel", 8'(sel), (e.owner < 0) ? 8'd7 : 8'(e.owner));
                chk("timeout_err", 8'(timeout_err), 8'(e.terr));
                chk("out_valid", 8'(out_valid), 8'(|(req & eg)));
            end
        end
    end

    initial begin
        logic [14:0] all_single, n_head, n_body, n_tail;
        all_single = fl(3'b101, 3'b101, 3'b101, 3'b101, 3'b101);
        step(1, 5'b0, '0, 0, 0);
        step(1, 5'b0, '0, 0, 0);
        // round robin over L, E, S with single-flit packets
        for (int i = 0; i < 8; i++) step(0, 5'b10101, all_single, 1, 0);
        // three-flit N packet with a stall while others request
        step(1, 5'b0, '0, 0, 0);
        n_head = fl(3'b001, 3'b001, 3'b001, 3'b001, 3'b001);
        n_body = fl(3'b001, 3'b010, 3'b001, 3'b001, 3'b001);
        n_tail = fl(3'b001, 3'b100, 3'b001, 3'b001, 3'b001);
        step(0, 5'b00010, n_head, 0, 0);
        step(0, 5'b11011, n_head, 1, 0);
        step(0, 5'b11011, n_body, 0, 0);
        step(0, 5'b11011, n_body, 0, 0);
        step(0, 5'b11011, n_body, 1, 0);
        step(0, 5'b11011, n_tail, 1, 0);
        step(0, 5'b00000, '0, 0, 0);
        // watchdog expiry with E waiting
        step(1, 5'b0, '0, 0, 4);
        step(0, 5'b00001, fl(3'b001, 3'b000, 3'b001, 3'b000, 3'b000), 0, 4);
        for (int i = 0; i < 8; i++) step(0, 5'b00101, fl(3'b010, 3'b000, 3'b001, 3'b000, 3'b000), 0, 4);
        // tail transfer coinciding with count reaching the limit
        step(1, 5'b0, '0, 0, 4);
        step(0, 5'b00001, fl(3'b001, 3'b000, 3'b000, 3'b000, 3'b000), 0, 4);
        for (int i = 0; i < 4; i++) step(0, 5'b00001, fl(3'b010, 3'b000, 3'b000, 3'b000, 3'b000), 0, 4);
        step(0, 5'b00001, fl(3'b100, 3'b000, 3'b000, 3'b000, 3'b000), 1, 4);
        step(0, 5'b00000, '0, 0, 4);
        // reset mid-packet on E, then E and W compete from L-first pointer
        step(1, 5'b0, '0, 0, 0);
        step(0, 5'b00100, fl(3'b000, 3'b000, 3'b001, 3'b000, 3'b000), 1, 0);
        step(0, 5'b00100, fl(3'b000, 3'b000, 3'b010, 3'b000, 3'b000), 1, 0);
        step(1, 5'b00100, fl(3'b000, 3'b000, 3'b010, 3'b000, 3'b000), 1, 0);
        step(0, 5'b01100, fl(3'b000, 3'b000, 3'b001, 3'b001, 3'b000), 0, 0);
        step(0, 5'b01100, fl(3'b000, 3'b000, 3'b010, 3'b001, 3'b000), 0, 0);
        // body-only request on W never wins until its head appears
        step(1, 5'b0, '0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 5'b01000, fl(3'b000, 3'b000, 3'b000, 3'b010, 3'b000), 1, 0);
        step(0, 5'b01000, fl(3'b000, 3'b000, 3'b000, 3'b001, 3'b000), 1, 0);
        step(0, 5'b01000, fl(3'b000, 3'b000, 3'b000, 3'b100, 3'b000), 1, 0);
        step(0, 5'b00000, '0, 0, 0);
        // counter must saturate, not wrap, so a late limit of all-ones fires at once
        step(1, 5'b0, '0, 0, 0);
        step(0, 5'b00001, fl(3'b001, 3'b000, 3'b000, 3'b000, 3'b000), 0, 0);
        for (int i = 0; i < 4100; i++) step(0, 5'b00011, fl(3'b010, 3'b001, 3'b000, 3'b000, 3'b000), 0, 0);
        for (int i = 0; i < 3; i++) step(0, 5'b00011, fl(3'b010, 3'b001, 3'b000, 3'b000, 3'b000), 0, CMAX);
        // random traffic
        begin
            int tm;
            tm = 0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(49) == 0) tm = $urandom_range(6);
                step($urandom_range(99) == 0, 5'($urandom), 15'($urandom),
                     $urandom_range(3) != 0, tm);
            end
        end
        @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
